// File: rtl/stream_join_n.sv
// N-channel stream join: waits for a beat on every channel, concatenates them
// and registers the result through a two-entry main/skid output buffer.

module stream_join_n_lane #(
    parameter bit HELD   = 1'b0,
    parameter bit MASTER = 1'b0
) (
    input  logic join_beat,
    input  logic last0,
    input  logic last_i,
    output logic ready,
    output logic mismatch
);
    // Held lanes keep their word for the whole packet and pop only on its last beat.
    assign ready    = join_beat & (HELD ? last0 : 1'b1);
    assign mismatch = join_beat & ~HELD & ~MASTER & (last_i ^ last0);
endmodule

module stream_join_n #(
    parameter int              N_CH      = 2,
    parameter int              DATA_WD   = 4,
    parameter logic [N_CH-1:0] HOLD_MASK = '0,
    parameter int              CNT_WD    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         s_valid,
    input  logic [N_CH*DATA_WD-1:0] s_data,
    input  logic [N_CH-1:0]         s_last,
    output logic [N_CH-1:0]         s_ready,
    output logic                    m_valid,
    output logic [N_CH*DATA_WD-1:0] m_data,
    output logic                    m_last,
    output logic [CNT_WD-1:0]       m_beat,
    input  logic                    m_ready,
    output logic                    err_last
);
    logic                    skid_valid;
    logic [N_CH*DATA_WD-1:0] skid_data;
    logic                    skid_last;
    logic [CNT_WD-1:0]       skid_beat;
    logic [CNT_WD-1:0]       cnt;
    logic                    space;
    logic                    join_beat;
    logic [N_CH-1:0]         mismatch;

    // Space comes only from the registered skid flag, so m_ready never reaches s_ready.
    assign space     = ~skid_valid;
    assign join_beat = (&s_valid) & space & ~rst;

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        stream_join_n_lane #(
            .HELD   (i != 0 && HOLD_MASK[i]),
            .MASTER (i == 0)
        ) u_lane (
            .join_beat (join_beat),
            .last0     (s_last[0]),
            .last_i    (s_last[i]),
            .ready     (s_ready[i]),
            .mismatch  (mismatch[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_last     <= 1'b0;
            m_beat     <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_last  <= 1'b0;
            skid_beat  <= '0;
        end else if (join_beat) begin
            if (!m_valid || m_ready) begin
                m_valid <= 1'b1;
                m_data  <= s_data;
                m_last  <= s_last[0];
                m_beat  <= cnt;
            end else begin
                skid_valid <= 1'b1;
                skid_data  <= s_data;
                skid_last  <= s_last[0];
                skid_beat  <= cnt;
            end
        end else if (m_ready) begin
            // No join implies either skid is full (promote it) or nothing new arrived.
            if (skid_valid) begin
                m_data     <= skid_data;
                m_last     <= skid_last;
                m_beat     <= skid_beat;
                skid_valid <= 1'b0;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            err_last <= 1'b0;
        end else if (join_beat) begin
            if (s_last[0])
                cnt <= '0;
            else if (!(&cnt))
                cnt <= cnt + CNT_WD'(1);
            if (|mismatch)
                err_last <= 1'b1;
        end
    end
endmodule

// File: doc/stream_join_n.md
# stream_join_n

N-channel AXI-Stream join with registered output and per-channel hold mode. Waits for every input channel to present a beat, concatenates them into one wide output beat, and forwards it through a two-entry skid buffer, so `m_ready` never reaches any `s_ready` combinationally. Channels marked "held" (e.g. per-packet headers or descriptors) are consumed only on the last beat of the channel-0 packet. Sits between independent producers and a single wide consumer, replacing two-input joins where more channels, packet-held channels or registered timing are needed.

## Interface
- `N_CH`, 2: number of input channels (2..16).
- `DATA_WD`, 4: data width per channel.
- `HOLD_MASK`, 0: `N_CH`-bit; bit i=1 makes channel i held (consumed only on the packet's last beat). Bit 0 is ignored; channel 0 is always the packet master.
- `CNT_WD`, 16: width of the beat index.

- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `s_valid`  in  N_CH  per-channel valid.
- `s_data`  in  N_CH*DATA_WD  channel i at `[i*DATA_WD +: DATA_WD]`.
- `s_last`  in  N_CH  per-channel last; only bit 0 defines packet boundaries.
- `s_ready`  out  N_CH  per-channel ready.
- `m_valid`  out  1  output beat valid.
- `m_data`  out  N_CH*DATA_WD  concatenation, channel 0 in LSBs.
- `m_last`  out  1  copy of channel-0 last for this beat.
- `m_beat`  out  CNT_WD  index of this beat within its packet (0 = first).
- `m_ready`  in  1  consumer ready.
- `err_last`  out  1  sticky: a non-held channel's last disagreed with channel 0.

## Operation
- `space` = skid entry empty (registered). `join` = AND of all `s_valid` and `space`.
- On `join`: `s_ready[i]` = 1 for non-held channels; for held channels, `s_ready[i]` = `s_last[0]`. Otherwise all `s_ready` = 0. `s_ready` may depend on `s_valid` of other channels and never on `m_ready`.
- Held channel data is sampled on every joined beat but is popped only on the last beat, so the same held word repeats across the packet.
- Beat counter `cnt`: on `join`, the beat is tagged `m_beat = cnt`; then `cnt` becomes 0 if `s_last[0]`, else `cnt+1`, saturating at all-ones. A saturated counter holds all-ones until last.
- `err_last`: on `join`, set if any non-held channel i≠0 has `s_last[i] != s_last[0]`. Cleared only by `rst`. Data still flows normally.
- Skid buffer, two entries (main/output and skid):
  - Main empty or draining (`m_ready`): the new beat loads main.
  - Main full and stalled: the new beat loads skid. `space` drops next cycle.
  - Main drains while skid full: skid moves to main and `space` returns next cycle.
  - No beat is dropped or duplicated. Order is preserved.
- `m_data`, `m_last` and `m_beat` stay stable while `m_valid & ~m_ready`.

## Timing
- Reset (async assert, sync use after deassert): `m_valid`=0, `m_data`=0, `m_last`=0, `m_beat`=0, `err_last`=0, `cnt`=0, skid empty. `s_ready`=0 while `rst` is high.
- Latency: `join` in cycle t puts the beat on `m_valid` in cycle t+1.
- Throughput: 1 beat/cycle with `m_ready` held high.
- Stall: after `m_ready` falls, at most one more beat is accepted (into skid). Then `s_ready`=0 until main drains.
- Recovery: on `m_ready` rising with both entries full, the skid beat appears at t+1 and a new `join` is possible at t+1.
- Simultaneous join and drain with main full and skid empty: the new beat goes to main, and skid stays empty.
- `rst` mid-packet: all buffered beats are discarded, `cnt`=0, and the next accepted beat has `m_beat`=0.

## Test plan
- N_CH=3, HOLD_MASK=0, `m_ready`=1. Send beats ch0=1,2,3, ch1=4,5,6, ch2=7,8,9 with last on beat 3 of all channels -> `m_data`=0x741,0x852,0x963 on consecutive cycles starting 1 cycle after the first join; `m_beat`=0,1,2; `m_last` only on 0x963; `err_last`=0.
- N_CH=2, HOLD_MASK=2'b10. Ch1 presents 0xA then 0xB; ch0 sends a 4-beat packet, then 1 beat with last -> first 4 outputs carry ch1=0xA and `s_ready[1]` pulses once, on the 4th beat. The 5th output carries 0xB with `m_beat`=0.
- Backpressure: continuous valid inputs. Drop `m_ready` for 5 cycles mid-stream -> exactly one extra beat is accepted after the drop, `s_ready`=0 for the remainder, and the sequence resumes in order with no loss or duplication.
- Random valids on all channels and random `m_ready` over 10k beats -> the output stream equals the scoreboard concatenation. No more than 2 beats are in flight.
- Last mismatch: ch1 asserts last on beat 2 while ch0 asserts it on beat 3 -> `err_last` rises the cycle after beat 2 joins and stays 1 until `rst`.
- CNT_WD=2. Send a 6-beat packet -> `m_beat`=0,1,2,3,3,3. Assert `rst` with 2 beats buffered -> `m_valid`=0 immediately, and the next beat after reset has `m_beat`=0.
